// File: rtl/range_counter_updown.sv
`default_nettype none
// ============================================================================
//  Module   : range_counter_updown
//  Purpose  : Bounded up/down counter with runtime-programmable bounds,
//             wrap or saturate at the ends of the range, parallel load,
//             count enable and self-correction of out-of-range states.
//  Revision : 1.0  initial release
// ============================================================================
module range_counter_updown #(
  parameter int WIDTH      = 8,
  parameter int LO_DEFAULT = 10,
  parameter int HI_DEFAULT = 40
) (
  input  logic             clk,
  input  logic             rst,       // synchronous, active-low
  input  logic             en,
  input  logic             up_dn,     // 1 = up, 0 = down
  input  logic             sat_mode,  // 0 = wrap, 1 = hold at bound
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             cfg_err
);

  // Reset values of the bound registers and the counter.
  localparam longint            C_LIMIT = longint'(1) << WIDTH;
  localparam logic [WIDTH-1:0]  C_LO    = WIDTH'(LO_DEFAULT);
  localparam logic [WIDTH-1:0]  C_HI    = WIDTH'(HI_DEFAULT);
  localparam logic [WIDTH-1:0]  C_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  // Refuse to elaborate with an unusable parameter set.
  generate
    if ((WIDTH < 2) || (WIDTH > 32) || (LO_DEFAULT < 0) ||
        (LO_DEFAULT > HI_DEFAULT) || (longint'(HI_DEFAULT) >= C_LIMIT)) begin : g_bad_params
      $error("range_counter_updown: illegal WIDTH/LO_DEFAULT/HI_DEFAULT combination");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             wrap_q, wrap_d;
  logic             cfg_err_q, cfg_err_d;

  logic             below_lo;
  logic             above_hi;
  logic             at_lo;
  logic             at_hi;

  // Range comparisons against the current bounds (all unsigned).
  always_comb begin
    below_lo = (count_q < lo_q);
    above_hi = (count_q > hi_q);
    at_lo    = (count_q == lo_q);
    at_hi    = (count_q == hi_q);
  end

  // Next-state selection: cfg_we > load > self-correct > count > hold.
  always_comb begin
    count_d   = count_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    wrap_d    = 1'b0;
    cfg_err_d = 1'b0;

    if (cfg_we) begin
      // A rejected write still consumes the cycle: no load, no step.
      if (cfg_lo <= cfg_hi) begin
        lo_d    = cfg_lo;
        hi_d    = cfg_hi;
        count_d = cfg_lo;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (load) begin
      // Out-of-range load values fall back to the lower bound silently.
      if ((load_val >= lo_q) && (load_val <= hi_q)) begin
        count_d = load_val;
      end else begin
        count_d = lo_q;
      end
    end else if (below_lo || above_hi) begin
      // Recover from upsets or illegal states even when not enabled.
      count_d = lo_q;
    end else if (en) begin
      if (up_dn) begin
        if (!at_hi) begin
          count_d = count_q + C_ONE;
        end else if (!sat_mode) begin
          count_d = lo_q;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_lo) begin
          count_d = count_q - C_ONE;
        end else if (!sat_mode) begin
          count_d = hi_q;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= C_LO;
      lo_q      <= C_LO;
      hi_q      <= C_HI;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Terminal count follows the direction and the current bound immediately.
  always_comb begin
    tc = up_dn ? at_hi : at_lo;
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_range_counter_updown.sv
`default_nettype none
// ============================================================================
//  Module   : tb_range_counter_updown
//  Purpose  : Directed self-checking bench for range_counter_updown, one
//             instance with the 8-bit defaults and one 4-bit instance with
//             bounds 3/9 for narrow-width and degenerate-range behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_range_counter_updown;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 8-bit instance, defaults 10/40
  logic       en, up_dn, sat_mode, load, cfg_we;
  logic [7:0] load_val, cfg_lo, cfg_hi, count;
  logic       tc, wrap, cfg_err;

  // 4-bit instance, defaults 3/9
  logic       b_en, b_up_dn, b_sat_mode, b_load, b_cfg_we;
  logic [3:0] b_load_val, b_cfg_lo, b_cfg_hi, b_count;
  logic       b_tc, b_wrap, b_cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  range_counter_updown #(.WIDTH(8), .LO_DEFAULT(10), .HI_DEFAULT(40)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .cfg_we(cfg_we), .cfg_lo(cfg_lo),
    .cfg_hi(cfg_hi), .count(count), .tc(tc), .wrap(wrap), .cfg_err(cfg_err)
  );

  range_counter_updown #(.WIDTH(4), .LO_DEFAULT(3), .HI_DEFAULT(9)) u_dut_w4 (
    .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up_dn), .sat_mode(b_sat_mode),
    .load(b_load), .load_val(b_load_val), .cfg_we(b_cfg_we), .cfg_lo(b_cfg_lo),
    .cfg_hi(b_cfg_hi), .count(b_count), .tc(b_tc), .wrap(b_wrap), .cfg_err(b_cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp;

    en = 0; up_dn = 1; sat_mode = 0; load = 0; cfg_we = 0;
    load_val = 0; cfg_lo = 0; cfg_hi = 0;
    b_en = 0; b_up_dn = 1; b_sat_mode = 0; b_load = 0; b_cfg_we = 0;
    b_load_val = 0; b_cfg_lo = 0; b_cfg_hi = 0;

    // ---------------- reset state ----------------
    rst = 0;
    tick(); tick();
    check("rst_count", count, 10);
    check("rst_wrap", wrap, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_tc_up", tc, 0);
    check("rst_b_count", b_count, 3);

    // ---------------- up/wrap through defaults ----------------
    rst = 1; en = 1; up_dn = 1; sat_mode = 0;
    exp = 10;
    repeat (30) begin
      tick();
      exp++;
      check("up_count", count, exp);
      check("up_tc", tc, (exp == 40) ? 1 : 0);
      check("up_wrap", wrap, 0);
    end
    tick();
    check("wrap_count", count, 10);
    check("wrap_pulse", wrap, 1);
    tick();
    check("after_wrap_count", count, 11);
    check("after_wrap_pulse", wrap, 0);

    // ---------------- down/saturate from load 12 (load beats en) ----------------
    up_dn = 0; sat_mode = 1; load = 1; load_val = 12;
    tick();
    check("dn_load", count, 12);
    load = 0;
    tick(); check("dn_11", count, 11);
    tick(); check("dn_10", count, 10); check("dn_tc", tc, 1);
    tick(); check("dn_sat1", count, 10); check("dn_sat1_wrap", wrap, 0);
    tick(); check("dn_sat2", count, 10); check("dn_sat2_wrap", wrap, 0);

    // ---------------- cfg 100/103 while counting ----------------
    up_dn = 1; sat_mode = 0; en = 1;
    cfg_we = 1; cfg_lo = 100; cfg_hi = 103;
    tick();
    check("cfg_count", count, 100);
    check("cfg_err_ok", cfg_err, 0);
    cfg_we = 0;
    tick(); check("cfg_101", count, 101);
    tick(); check("cfg_102", count, 102);
    tick(); check("cfg_103", count, 103); check("cfg_tc", tc, 1);
    tick(); check("cfg_wrap_count", count, 100); check("cfg_wrap", wrap, 1);

    // Rejected write also blocks a simultaneous load and count step.
    cfg_we = 1; cfg_lo = 50; cfg_hi = 20; load = 1; load_val = 102;
    tick();
    check("rej_count", count, 100);
    check("rej_err", cfg_err, 1);
    check("rej_wrap", wrap, 0);
    cfg_we = 0; load = 0; en = 0;
    tick();
    check("rej_err_clear", cfg_err, 0);
    check("rej_hold", count, 100);

    // Bounds remain 100/103.
    load = 1; load_val = 99;
    tick(); check("bnd_lo_kept", count, 100);
    load_val = 103;
    tick(); check("bnd_hi_load", count, 103); check("bnd_hi_tc", tc, 1);
    load_val = 104;
    tick(); check("bnd_hi_kept", count, 100);
    load = 0;

    // ---------------- load behaviour with bounds 10/40 ----------------
    cfg_we = 1; cfg_lo = 10; cfg_hi = 40;
    tick(); check("cfg_back", count, 10);
    cfg_we = 0;
    load = 1; load_val = 5;
    tick(); check("load_low", count, 10);
    load_val = 25; en = 1;
    tick(); check("load_en", count, 25);
    load = 0;
    tick(); check("load_then_up", count, 26);

    // ---------------- self-correct from illegal state ----------------
    en = 0;
    u_dut.count_q = 8'd200;
    tick();
    check("selfcorr", count, 10);

    // ---------------- reset mid-count clears pending pulse and bounds ----------------
    cfg_we = 1; cfg_lo = 20; cfg_hi = 30;
    tick(); check("pre_rst_cfg", count, 20);
    cfg_we = 0; load = 1; load_val = 30;
    tick(); check("pre_rst_load", count, 30);
    load = 0; en = 1;
    tick(); check("pre_rst_wrap_cnt", count, 20); check("pre_rst_wrap", wrap, 1);
    rst = 0;
    tick();
    check("midrst_count", count, 10);
    check("midrst_wrap", wrap, 0);
    check("midrst_cfg_err", cfg_err, 0);
    check("midrst_b_count", b_count, 3);
    rst = 1; en = 0; load = 1; load_val = 40;
    tick(); check("midrst_hi_restored", count, 40);
    load = 0;

    // ---------------- WIDTH=4 instance ----------------
    b_cfg_we = 1; b_cfg_lo = 0; b_cfg_hi = 15;
    tick(); check("w4_cfg", b_count, 0);
    b_cfg_we = 0; b_load = 1; b_load_val = 15;
    tick(); check("w4_load15", b_count, 15); check("w4_tc15", b_tc, 1);
    b_load = 0; b_en = 1; b_up_dn = 1; b_sat_mode = 0;
    tick(); check("w4_wrap_cnt", b_count, 0); check("w4_wrap", b_wrap, 1);

    // Degenerate range 7/7.
    b_cfg_we = 1; b_cfg_lo = 7; b_cfg_hi = 7;
    tick(); check("w4_deg_cfg", b_count, 7); check("w4_deg_cfg_wrap", b_wrap, 0);
    b_cfg_we = 0;
    tick(); check("w4_deg1", b_count, 7); check("w4_deg1_wrap", b_wrap, 1);
    tick(); check("w4_deg2", b_count, 7); check("w4_deg2_wrap", b_wrap, 1);
    check("w4_deg_tc_up", b_tc, 1);
    b_up_dn = 0;
    #1; check("w4_deg_tc_dn", b_tc, 1);
    tick(); check("w4_deg_dn_wrap", b_wrap, 1); check("w4_deg_dn", b_count, 7);
    b_sat_mode = 1;
    tick(); check("w4_deg_sat_wrap", b_wrap, 0);
    b_sat_mode = 0;
    tick(); check("w4_deg3_wrap", b_wrap, 1);
    rst = 0;
    tick();
    check("w4_rst_count", b_count, 3);
    check("w4_rst_wrap", b_wrap, 0);
    rst = 1; b_en = 1; b_up_dn = 1;
    tick(); check("w4_after_rst", b_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end (checks %0d)", n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
